fb_write_scheduler: RTL and testbench
=====================================

Name: fb_write_scheduler

Overview:
- Sequences all writes into the double-buffered frame buffer.
- Arbitrates pixel writes from two requesters (rasterizer, blitter) round-robin onto the single write port.
- On frame completion, waits for vertical blank, issues a one-cycle buffer swap, then optionally sweeps the new back buffer with a clear colour.
- Sits between the draw engines and the frame buffer write/swap inputs.

Parameters:
H_RES, 640, horizontal pixel count
V_RES, 480, vertical pixel count
X_W, 10, x coordinate width
Y_W, 10, y coordinate width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
vblank  in  1  level, high during display vertical blank
frame_done  in  1  single-cycle pulse, renderer finished current frame
clear_en  in  1  clear back buffer after swap; sampled in SWAP
clear_color  in  24  {r,g,b} clear value
req0_valid  in  1  requester 0 write valid
req0_ready  out  1  requester 0 accepted (combinational)
req0_x  in  X_W  requester 0 pixel x
req0_y  in  Y_W  requester 0 pixel y
req0_rgb  in  24  requester 0 colour {r,g,b}
req1_valid  in  1  requester 1 write valid
req1_ready  out  1  requester 1 accepted (combinational)
req1_x  in  X_W  requester 1 pixel x
req1_y  in  Y_W  requester 1 pixel y
req1_rgb  in  24  requester 1 colour {r,g,b}
wr_en  out  1  frame buffer write strobe
wr_x  out  X_W  write x
wr_y  out  Y_W  write y
wr_r  out  8  write red
wr_g  out  8  write green
wr_b  out  8  write blue
swap  out  1  one-cycle buffer swap pulse
busy  out  1  high whenever state != DRAW
frame_count  out  16  completed swaps, wraps at 0xFFFF -> 0

Behaviour:
- Reset, async on rst_n low:
  - state = DRAW.
  - wr_en, swap, wr_x/y/r/g/b, frame_count, sweep counters = 0.
  - last_grant = 1, so req0 wins first contention.
  - Reset during CLEAR aborts the sweep immediately; wr_en drops in the same instant.
- States: DRAW, WAIT_VBLANK, SWAP, CLEAR.
- DRAW:
  - Both valid: grant the requester not equal to last_grant.
  - One valid: grant that one.
  - reqN_ready = grant, combinational, at most one high per cycle.
  - Handshake is valid & ready. last_grant updates only on a handshake.
  - Accepted write appears registered the next cycle: wr_en = 1, wr_* = accepted data. One pixel per cycle max.
  - Out-of-range coordinates (x >= H_RES or y >= V_RES) are accepted (ready high) but dropped; wr_en stays 0.
  - frame_done -> WAIT_VBLANK next cycle. A handshake in the same cycle as frame_done still completes and is written.
- WAIT_VBLANK:
  - Both readies 0.
  - vblank is checked from the first cycle in this state; if high -> SWAP next cycle.
- SWAP:
  - swap = 1 for exactly this cycle; frame_count increments.
  - clear_en = 1 -> CLEAR, with x_cnt = 0 and y_cnt = 0.
  - clear_en = 0 -> DRAW.
- CLEAR:
  - Readies 0. Each cycle registers wr_en = 1, wr_x = x_cnt, wr_y = y_cnt, wr_rgb = clear_color.
  - x_cnt increments; at H_RES-1 it wraps to 0 and y_cnt increments.
  - After issuing (H_RES-1, V_RES-1) -> DRAW. Total exactly H_RES*V_RES writes.
  - clear_color changes mid-sweep take effect on the next pixel.
- frame_done outside DRAW is ignored (not latched).
- busy is registered from state, 0 only in DRAW.
- wr_en is 0 in every cycle not stated above.

Test Plan:
- Reset, then req0_valid = 1 with (5, 7, 0xFF0000) -> req0_ready = 1 same cycle; next cycle wr_en = 1, wr_x = 5, wr_y = 7, wr_r = 0xFF, wr_g = 0, wr_b = 0.
- Both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; never both ready; wr_en high for 6 consecutive cycles.
- req1 writes (640, 0) and (0, 480) -> ready high both times; wr_en stays 0.
- Params H_RES = 4, V_RES = 2, clear_en = 1, clear_color = 0x123456; frame_done with vblank = 0 for 3 cycles, then vblank = 1:
  - swap pulses once after vblank rises; frame_count = 1.
  - Then 8 writes in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1), all colour 0x123456.
  - busy drops after the last write; readies 0 throughout.
- frame_done with clear_en = 0, vblank = 1 -> WAIT_VBLANK one cycle, swap one cycle, back in DRAW 3 cycles after frame_done; no clear writes.
- rst_n low mid-CLEAR after 3 pixels -> wr_en 0 immediately; frame_count 0; after release, req0 write is accepted in DRAW.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Frame buffer write scheduler: round-robin pixel arbitration between two draw engines,
// vblank-synchronised buffer swap and an optional clear sweep of the new back buffer.
module fb_write_scheduler #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int X_W   = 10,
    parameter int Y_W   = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           vblank,
    input  logic           frame_done,
    input  logic           clear_en,
    input  logic [23:0]    clear_color,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [X_W-1:0] req0_x,
    input  logic [Y_W-1:0] req0_y,
    input  logic [23:0]    req0_rgb,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [X_W-1:0] req1_x,
    input  logic [Y_W-1:0] req1_y,
    input  logic [23:0]    req1_rgb,
    output logic           wr_en,
    output logic [X_W-1:0] wr_x,
    output logic [Y_W-1:0] wr_y,
    output logic [7:0]     wr_r,
    output logic [7:0]     wr_g,
    output logic [7:0]     wr_b,
    output logic           swap,
    output logic           busy,
    output logic [15:0]    frame_count
);

    typedef enum logic [1:0] {DRAW, WAIT_VBLANK, SWAP, CLEAR} state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
    localparam logic [X_W:0]   H_LIM  = (X_W + 1)'(H_RES);
    localparam logic [Y_W:0]   V_LIM  = (Y_W + 1)'(V_RES);

    state_t         state, state_next;
    logic           last_grant;
    logic           grant0, grant1;
    logic           req0_in, req1_in;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;

    assign req0_in    = ({1'b0, req0_x} < H_LIM) && ({1'b0, req0_y} < V_LIM);
    assign req1_in    = ({1'b0, req1_x} < H_LIM) && ({1'b0, req1_y} < V_LIM);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Under contention the requester that did not win the last handshake is granted.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        case (state)
            DRAW: begin
                if (req0_valid && (!req1_valid || last_grant)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (frame_done) begin
                    state_next = WAIT_VBLANK;
                end
            end
            WAIT_VBLANK: begin
                if (vblank) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                state_next = clear_en ? CLEAR : DRAW;
            end
            CLEAR: begin
                if (x_cnt == X_LAST && y_cnt == Y_LAST) begin
                    state_next = DRAW;
                end
            end
            default: state_next = DRAW;
        endcase
    end

    // swap and busy are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DRAW;
            last_grant  <= 1'b1;
            wr_en       <= 1'b0;
            wr_x        <= '0;
            wr_y        <= '0;
            wr_r        <= '0;
            wr_g        <= '0;
            wr_b        <= '0;
            swap        <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != DRAW);
            swap  <= (state_next == SWAP);
            wr_en <= 1'b0;
            if (state == SWAP) begin
                frame_count <= frame_count + 16'd1;
                x_cnt       <= '0;
                y_cnt       <= '0;
            end
            if (grant0) begin
                last_grant <= 1'b0;
                if (req0_in) begin
                    wr_en <= 1'b1;
                    wr_x  <= req0_x;
                    wr_y  <= req0_y;
                    {wr_r, wr_g, wr_b} <= req0_rgb;
                end
            end else if (grant1) begin
                last_grant <= 1'b1;
                if (req1_in) begin
                    wr_en <= 1'b1;
                    wr_x  <= req1_x;
                    wr_y  <= req1_y;
                    {wr_r, wr_g, wr_b} <= req1_rgb;
                end
            end
            if (state == CLEAR) begin
                wr_en <= 1'b1;
                wr_x  <= x_cnt;
                wr_y  <= y_cnt;
                {wr_r, wr_g, wr_b} <= clear_color;
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: a full-size instance for arbitration and
// a 4x2 instance for the clear sweep, both checked against an in-bench reference model.
module tb_fb_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, vblank, frame_done, clear_en, clear_en_b;
    logic [23:0] clear_color;
    logic        req0_valid, req1_valid;
    logic [9:0]  req0_x, req0_y, req1_x, req1_y;
    logic [23:0] req0_rgb, req1_rgb;

    logic        req0_ready_b, req1_ready_b, wr_en_b, swap_b, busy_b;
    logic [9:0]  wr_x_b, wr_y_b;
    logic [7:0]  wr_r_b, wr_g_b, wr_b_b;
    logic [15:0] frame_count_b;

    logic        req0_ready_s, req1_ready_s, wr_en_s, swap_s, busy_s;
    logic [9:0]  wr_x_s, wr_y_s;
    logic [7:0]  wr_r_s, wr_g_s, wr_b_s;
    logic [15:0] frame_count_s;

    int checks = 0;
    int passed = 0;
    int model_last;
    int fc_b, fc_s;

    always #5 clk = ~clk;

    fb_write_scheduler #(.H_RES(640), .V_RES(480), .X_W(10), .Y_W(10)) dut_big (
        .clk(clk), .rst_n(rst_n), .vblank(vblank), .frame_done(frame_done),
        .clear_en(clear_en_b), .clear_color(clear_color),
        .req0_valid(req0_valid), .req0_ready(req0_ready_b), .req0_x(req0_x), .req0_y(req0_y), .req0_rgb(req0_rgb),
        .req1_valid(req1_valid), .req1_ready(req1_ready_b), .req1_x(req1_x), .req1_y(req1_y), .req1_rgb(req1_rgb),
        .wr_en(wr_en_b), .wr_x(wr_x_b), .wr_y(wr_y_b), .wr_r(wr_r_b), .wr_g(wr_g_b), .wr_b(wr_b_b),
        .swap(swap_b), .busy(busy_b), .frame_count(frame_count_b)
    );

    fb_write_scheduler #(.H_RES(4), .V_RES(2), .X_W(10), .Y_W(10)) dut_small (
        .clk(clk), .rst_n(rst_n), .vblank(vblank), .frame_done(frame_done),
        .clear_en(clear_en), .clear_color(clear_color),
        .req0_valid(req0_valid), .req0_ready(req0_ready_s), .req0_x(req0_x), .req0_y(req0_y), .req0_rgb(req0_rgb),
        .req1_valid(req1_valid), .req1_ready(req1_ready_s), .req1_x(req1_x), .req1_y(req1_y), .req1_rgb(req1_rgb),
        .wr_en(wr_en_s), .wr_x(wr_x_s), .wr_y(wr_y_s), .wr_r(wr_r_s), .wr_g(wr_g_s), .wr_b(wr_b_s),
        .swap(swap_s), .busy(busy_s), .frame_count(frame_count_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0; frame_done = 1'b0; vblank = 1'b0;
        clear_en = 1'b0; clear_en_b = 1'b0; clear_color = 24'h0;
        req0_x = '0; req0_y = '0; req0_rgb = '0; req1_x = '0; req1_y = '0; req1_rgb = '0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        model_last = 1; fc_b = 0; fc_s = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        checks++; if (wr_en_b !== 1'b0) $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en_b); else passed++;
        checks++; if (swap_b !== 1'b0) $display("[TB] FAIL reset_swap: got %b expected 0", swap_b); else passed++;
        checks++; if (busy_b !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_b); else passed++;
        checks++; if (frame_count_b !== 16'd0) $display("[TB] FAIL reset_frame_count: got %0d expected 0", frame_count_b); else passed++;
        checks++; if ({wr_x_b, wr_y_b, wr_r_b, wr_g_b, wr_b_b} !== 44'd0)
            $display("[TB] FAIL reset_wr_data: got %h expected 0", {wr_x_b, wr_y_b, wr_r_b, wr_g_b, wr_b_b}); else passed++;
        @(negedge clk) rst_n = 1'b1;
        tick();
        model_last = 1; fc_b = 0; fc_s = 0;
        checks++; if (wr_en_s !== 1'b0 || busy_s !== 1'b0)
            $display("[TB] FAIL reset_small_idle: got wr_en=%b busy=%b expected 0/0", wr_en_s, busy_s); else passed++;
    endtask

    task automatic test_single_write();
        req0_valid = 1'b1; req0_x = 10'd5; req0_y = 10'd7; req0_rgb = 24'hFF0000;
        #1;
        checks++; if (req0_ready_b !== 1'b1 || req1_ready_b !== 1'b0)
            $display("[TB] FAIL single_ready: got %b%b expected 10", req0_ready_b, req1_ready_b); else passed++;
        tick();
        req0_valid = 1'b0;
        model_last = 0;
        checks++; if (wr_en_b !== 1'b1) $display("[TB] FAIL single_wr_en: got %b expected 1", wr_en_b); else passed++;
        checks++; if (wr_x_b !== 10'd5 || wr_y_b !== 10'd7)
            $display("[TB] FAIL single_xy: got (%0d,%0d) expected (5,7)", wr_x_b, wr_y_b); else passed++;
        checks++; if (wr_r_b !== 8'hFF || wr_g_b !== 8'h00 || wr_b_b !== 8'h00)
            $display("[TB] FAIL single_rgb: got %h%h%h expected ff0000", wr_r_b, wr_g_b, wr_b_b); else passed++;
        tick();
        checks++; if (wr_en_b !== 1'b0) $display("[TB] FAIL single_no_repeat: got %b expected 0", wr_en_b); else passed++;
    endtask

    task automatic test_back_to_back();
        int exp_g;
        logic [9:0] ex;
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_x = 10'(i); req0_y = 10'(20 + i); req0_rgb = 24'h100000 + 24'(i);
            req1_x = 10'(100 + i); req1_y = 10'(200 + i); req1_rgb = 24'h000100 + 24'(i);
            #1;
            exp_g = (model_last == 0) ? 1 : 0;
            ex = (exp_g == 0) ? req0_x : req1_x;
            checks++; if (req0_ready_b !== (exp_g == 0) || req1_ready_b !== (exp_g == 1))
                $display("[TB] FAIL b2b_grant[%0d]: got %b%b expected grant %0d", i, req0_ready_b, req1_ready_b, exp_g); else passed++;
            tick();
            model_last = exp_g;
            checks++; if (wr_en_b !== 1'b1 || wr_x_b !== ex)
                $display("[TB] FAIL b2b_write[%0d]: got en=%b x=%0d expected en=1 x=%0d", i, wr_en_b, wr_x_b, ex); else passed++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [9:0] xs [2];
        logic [9:0] ys [2];
        xs[0] = 10'd640; ys[0] = 10'd0;
        xs[1] = 10'd0;   ys[1] = 10'd480;
        for (int i = 0; i < 2; i++) begin
            req1_valid = 1'b1; req1_x = xs[i]; req1_y = ys[i]; req1_rgb = 24'hABCDEF;
            #1;
            checks++; if (req1_ready_b !== 1'b1) $display("[TB] FAIL oor_ready[%0d]: got %b expected 1", i, req1_ready_b); else passed++;
            tick();
            model_last = 1;
            checks++; if (wr_en_b !== 1'b0) $display("[TB] FAIL oor_dropped[%0d]: got %b expected 0", i, wr_en_b); else passed++;
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_random();
        int exp_g, ax, ay;
        logic [23:0] argb;
        logic in_range;
        for (int i = 0; i < 60; i++) begin
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_x = 10'($urandom_range(0, 700)); req0_y = 10'($urandom_range(0, 520)); req0_rgb = 24'($urandom);
            req1_x = 10'($urandom_range(0, 700)); req1_y = 10'($urandom_range(0, 520)); req1_rgb = 24'($urandom);
            #1;
            if (req0_valid && req1_valid) exp_g = 1 - model_last;
            else if (req0_valid) exp_g = 0;
            else if (req1_valid) exp_g = 1;
            else exp_g = -1;
            ax = (exp_g == 1) ? int'(req1_x) : int'(req0_x);
            ay = (exp_g == 1) ? int'(req1_y) : int'(req0_y);
            argb = (exp_g == 1) ? req1_rgb : req0_rgb;
            in_range = (exp_g >= 0) && (ax < 640) && (ay < 480);
            checks++; if (req0_ready_b !== (exp_g == 0) || req1_ready_b !== (exp_g == 1))
                $display("[TB] FAIL rand_grant[%0d]: got %b%b expected grant %0d", i, req0_ready_b, req1_ready_b, exp_g); else passed++;
            tick();
            if (exp_g >= 0) model_last = exp_g;
            checks++; if (wr_en_b !== in_range) $display("[TB] FAIL rand_wr_en[%0d]: got %b expected %b", i, wr_en_b, in_range); else passed++;
            if (in_range) begin
                checks++; if (int'(wr_x_b) != ax || int'(wr_y_b) != ay || {wr_r_b, wr_g_b, wr_b_b} !== argb)
                    $display("[TB] FAIL rand_data[%0d]: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                             i, wr_x_b, wr_y_b, {wr_r_b, wr_g_b, wr_b_b}, ax, ay, argb); else passed++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_clear();
        logic [23:0] col;
        int px, py;
        do_reset();
        clear_en = 1'b1; clear_color = 24'h123456; frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy_s !== 1'b1 || swap_s !== 1'b0)
                $display("[TB] FAIL clr_wait[%0d]: got busy=%b swap=%b expected 1/0", i, busy_s, swap_s); else passed++;
            tick();
        end
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        req0_valid = 1'b1; req0_x = 10'd1; req0_y = 10'd1; req0_rgb = 24'hFFFFFF;
        checks++; if (swap_s !== 1'b1) $display("[TB] FAIL clr_swap: got %b expected 1", swap_s); else passed++;
        col = 24'h123456;
        fc_s++;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 4) clear_color = 24'hABCDEF;
            #1;
            checks++; if (req0_ready_s !== 1'b0 || swap_s !== 1'b0 || busy_s !== 1'b1)
                $display("[TB] FAIL clr_cycle[%0d]: got ready=%b swap=%b busy=%b expected 0/0/1", k, req0_ready_s, swap_s, busy_s); else passed++;
            if (k == 0) begin
                checks++; if (int'(frame_count_s) != fc_s) $display("[TB] FAIL clr_frame_count: got %0d expected %0d", frame_count_s, fc_s); else passed++;
            end else begin
                px = (k - 1) % 4; py = (k - 1) / 4;
                checks++; if (wr_en_s !== 1'b1 || int'(wr_x_s) != px || int'(wr_y_s) != py || {wr_r_s, wr_g_s, wr_b_s} !== col)
                    $display("[TB] FAIL clr_pixel[%0d]: got en=%b (%0d,%0d,%h) expected (%0d,%0d,%h)",
                             k - 1, wr_en_s, wr_x_s, wr_y_s, {wr_r_s, wr_g_s, wr_b_s}, px, py, col); else passed++;
            end
            col = clear_color;
        end
        req0_valid = 1'b0;
        model_last = 0;
        tick();
        checks++; if (wr_en_s !== 1'b1 || wr_x_s !== 10'd3 || wr_y_s !== 10'd1 || {wr_r_s, wr_g_s, wr_b_s} !== 24'hABCDEF)
            $display("[TB] FAIL clr_last_pixel: got en=%b (%0d,%0d,%h) expected (3,1,abcdef)",
                     wr_en_s, wr_x_s, wr_y_s, {wr_r_s, wr_g_s, wr_b_s}); else passed++;
        checks++; if (busy_s !== 1'b0) $display("[TB] FAIL clr_busy_drop: got %b expected 0", busy_s); else passed++;
        tick();
        checks++; if (wr_en_s !== 1'b0) $display("[TB] FAIL clr_done: got %b expected 0", wr_en_s); else passed++;
        clear_en = 1'b0;
    endtask

    task automatic test_no_clear();
        do_reset();
        clear_en = 1'b0; vblank = 1'b1; frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        checks++; if (busy_b !== 1'b1 || swap_b !== 1'b0 || wr_en_b !== 1'b0)
            $display("[TB] FAIL noclr_wait: got busy=%b swap=%b en=%b expected 1/0/0", busy_b, swap_b, wr_en_b); else passed++;
        tick();
        checks++; if (swap_b !== 1'b1 || wr_en_b !== 1'b0)
            $display("[TB] FAIL noclr_swap: got swap=%b en=%b expected 1/0", swap_b, wr_en_b); else passed++;
        tick();
        fc_b++; fc_s++;
        checks++; if (busy_b !== 1'b0 || swap_b !== 1'b0 || wr_en_b !== 1'b0)
            $display("[TB] FAIL noclr_back: got busy=%b swap=%b en=%b expected 0/0/0", busy_b, swap_b, wr_en_b); else passed++;
        checks++; if (int'(frame_count_b) != fc_b || int'(frame_count_s) != fc_s)
            $display("[TB] FAIL noclr_count: got %0d/%0d expected %0d/%0d", frame_count_b, frame_count_s, fc_b, fc_s); else passed++;
        checks++; if (busy_s !== 1'b0 || wr_en_s !== 1'b0)
            $display("[TB] FAIL noclr_small: got busy=%b en=%b expected 0/0", busy_s, wr_en_s); else passed++;
        vblank = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int seen;
        do_reset();
        clear_en = 1'b1; clear_color = 24'h0F0F0F; vblank = 1'b1; frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            tick();
            if (wr_en_s === 1'b1) seen++;
        end
        checks++; if (seen != 3) $display("[TB] FAIL midclr_pixels: got %0d expected 3", seen); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wr_en_s !== 1'b0) $display("[TB] FAIL midclr_wr_en: got %b expected 0", wr_en_s); else passed++;
        checks++; if (frame_count_s !== 16'd0 || busy_s !== 1'b0)
            $display("[TB] FAIL midclr_state: got count=%0d busy=%b expected 0/0", frame_count_s, busy_s); else passed++;
        idle();
        @(negedge clk) rst_n = 1'b1;
        tick();
        model_last = 1; fc_b = 0; fc_s = 0;
        req0_valid = 1'b1; req0_x = 10'd2; req0_y = 10'd1; req0_rgb = 24'h00FF00;
        #1;
        checks++; if (req0_ready_s !== 1'b1) $display("[TB] FAIL midclr_ready: got %b expected 1", req0_ready_s); else passed++;
        tick();
        req0_valid = 1'b0;
        model_last = 0;
        checks++; if (wr_en_s !== 1'b1 || wr_x_s !== 10'd2 || wr_y_s !== 10'd1 || {wr_r_s, wr_g_s, wr_b_s} !== 24'h00FF00)
            $display("[TB] FAIL midclr_write: got en=%b (%0d,%0d,%h) expected (2,1,00ff00)",
                     wr_en_s, wr_x_s, wr_y_s, {wr_r_s, wr_g_s, wr_b_s}); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_clear();
        test_no_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
